// File: rtl/note_player_pkg.sv
// Shared widths, constants and FSM encoding for the note player.
package note_player_pkg;

    localparam int NOTE_W  = 6;
    localparam int DUR_W   = 6;
    localparam int STEP_W  = 20;
    localparam int PHASE_W = 22;

    localparam logic [NOTE_W-1:0] REST_NOTE = '0;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StPlaying
    } state_e;

endpackage

// File: rtl/frequency_rom.sv
// Combinational note -> phase-step table: round(440*2^((n-49)/12) * 2^22 / 48000).
module frequency_rom
    import note_player_pkg::*;
(
    input  logic [NOTE_W-1:0] note,
    output logic [STEP_W-1:0] step
);

    always_comb begin
        step = '0;
        case (note)
            6'd1:  step = 20'd2403;   6'd2:  step = 20'd2546;   6'd3:  step = 20'd2697;
            6'd4:  step = 20'd2858;   6'd5:  step = 20'd3028;   6'd6:  step = 20'd3208;
            6'd7:  step = 20'd3398;   6'd8:  step = 20'd3600;   6'd9:  step = 20'd3815;
            6'd10: step = 20'd4041;   6'd11: step = 20'd4282;   6'd12: step = 20'd4536;
            6'd13: step = 20'd4806;   6'd14: step = 20'd5092;   6'd15: step = 20'd5395;
            6'd16: step = 20'd5715;   6'd17: step = 20'd6055;   6'd18: step = 20'd6415;
            6'd19: step = 20'd6797;   6'd20: step = 20'd7201;   6'd21: step = 20'd7629;
            6'd22: step = 20'd8083;   6'd23: step = 20'd8563;   6'd24: step = 20'd9072;
            6'd25: step = 20'd9612;   6'd26: step = 20'd10184;  6'd27: step = 20'd10789;
            6'd28: step = 20'd11431;  6'd29: step = 20'd12110;  6'd30: step = 20'd12830;
            6'd31: step = 20'd13593;  6'd32: step = 20'd14402;  6'd33: step = 20'd15258;
            6'd34: step = 20'd16165;  6'd35: step = 20'd17127;  6'd36: step = 20'd18145;
            6'd37: step = 20'd19224;  6'd38: step = 20'd20367;  6'd39: step = 20'd21578;
            6'd40: step = 20'd22861;  6'd41: step = 20'd24221;  6'd42: step = 20'd25661;
            6'd43: step = 20'd27187;  6'd44: step = 20'd28803;  6'd45: step = 20'd30516;
            6'd46: step = 20'd32331;  6'd47: step = 20'd34253;  6'd48: step = 20'd36290;
            6'd49: step = 20'd38448;  6'd50: step = 20'd40734;  6'd51: step = 20'd43156;
            6'd52: step = 20'd45722;  6'd53: step = 20'd48441;  6'd54: step = 20'd51322;
            6'd55: step = 20'd54373;  6'd56: step = 20'd57607;  6'd57: step = 20'd61032;
            6'd58: step = 20'd64661;  6'd59: step = 20'd68506;  6'd60: step = 20'd72580;
            6'd61: step = 20'd76896;  6'd62: step = 20'd81468;  6'd63: step = 20'd86312;
            default: step = '0;
        endcase
    end

endmodule

// File: rtl/note_player.sv
// Plays one note at a time: loads its phase step, counts beats, advances the phase accumulator.
module note_player
    import note_player_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               play,
    input  logic [NOTE_W-1:0]  note,
    input  logic [DUR_W-1:0]   duration,
    input  logic               new_note,
    input  logic               beat,
    input  logic               generate_next_sample,
    output logic               note_done,
    output logic [STEP_W-1:0]  step_size,
    output logic [PHASE_W-1:0] phase,
    output logic               busy
);

    state_e              state_q, state_d;
    logic [NOTE_W-1:0]   note_q, note_d;
    logic [DUR_W-1:0]    dur_q, dur_d;
    logic [DUR_W-1:0]    beats_left_q, beats_left_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [PHASE_W-1:0]  phase_q, phase_d;
    logic [NOTE_W-1:0]   rom_addr;
    logic [STEP_W-1:0]   rom_step;
    logic                done;
    logic                accept;

    // The done cycle counts as idle for acceptance, so notes can run back-to-back.
    assign done     = (state_q == StPlaying) && (beats_left_q == '0);
    assign accept   = new_note && ((state_q == StIdle) || done);
    assign rom_addr = accept ? note : note_q;

    frequency_rom u_rom (
        .note (rom_addr),
        .step (rom_step)
    );

    always_comb begin
        state_d      = state_q;
        note_d       = note_q;
        dur_d        = dur_q;
        beats_left_d = beats_left_q;
        step_d       = step_q;
        phase_d      = phase_q;

        if (accept) begin
            note_d  = note;
            dur_d   = duration;
            step_d  = rom_step;
            state_d = StLoad;
        end else begin
            unique case (state_q)
                StIdle: ;
                StLoad: begin
                    step_d       = rom_step;
                    beats_left_d = dur_q;
                    state_d      = StPlaying;
                end
                StPlaying: begin
                    if (done) begin
                        state_d = StIdle;
                    end else if (play && beat) begin
                        beats_left_d = beats_left_q - 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        if ((state_q == StPlaying) && play && generate_next_sample) begin
            phase_d = phase_q + PHASE_W'(step_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            note_q       <= REST_NOTE;
            dur_q        <= '0;
            beats_left_q <= '0;
            step_q       <= '0;
            phase_q      <= '0;
        end else begin
            state_q      <= state_d;
            note_q       <= note_d;
            dur_q        <= dur_d;
            beats_left_q <= beats_left_d;
            step_q       <= step_d;
            phase_q      <= phase_d;
        end
    end

    assign note_done = done;
    assign busy      = (state_q != StIdle) && !done;
    assign step_size = step_q;
    assign phase     = phase_q;

endmodule

// File: tb/tb_note_player.sv
// Scenario tasks plus a randomized run against a rule-level reference model.
module tb_note_player;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        play = 1'b0;
    logic [5:0]  note = '0;
    logic [5:0]  duration = '0;
    logic        new_note = 1'b0;
    logic        beat = 1'b0;
    logic        gen = 1'b0;
    logic        note_done;
    logic        busy;
    logic [19:0] step_size;
    logic [21:0] phase;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    note_player dut (
        .clk                  (clk),
        .reset                (reset),
        .play                 (play),
        .note                 (note),
        .duration             (duration),
        .new_note             (new_note),
        .beat                 (beat),
        .generate_next_sample (gen),
        .note_done            (note_done),
        .step_size            (step_size),
        .phase                (phase),
        .busy                 (busy)
    );

    // Expected step straight from the tuning formula.
    function automatic int exp_step(input int n);
        real f;
        if (n == 0) return 0;
        f = 440.0 * (2.0 ** ((n - 49) / 12.0)) * 4194304.0 / 48000.0;
        return int'($floor(f + 0.5));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        new_note = 0; beat = 0; gen = 0; play = 0;
        reset = 1;
        tick();
        reset = 0;
    endtask

    task automatic start_note(input int n, input int d);
        note = 6'(n); duration = 6'(d); new_note = 1;
        tick();
        new_note = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        tick(); tick();
        total++; if (note_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", note_done); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (step_size !== 20'd0) begin bad++; $display("FAIL reset_step: got %0d want 0", step_size); end
        total++; if (phase !== 22'd0) begin bad++; $display("FAIL reset_phase: got %0d want 0", phase); end
        reset = 0;
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_basic();
        int ph = 0;
        int s = exp_step(49);
        apply_reset();
        play = 1;
        start_note(49, 3);
        total++; if (step_size !== 20'(s)) begin bad++; $display("FAIL basic_step: got %0d want %0d", step_size, s); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy_load: got %b want 1", busy); end
        tick();
        gen = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            ph = (ph + s) % 4194304;
        end
        gen = 0;
        total++; if (phase !== 22'(ph)) begin bad++; $display("FAIL basic_phase: got %0d want %0d", phase, ph); end
        for (int b = 1; b <= 3; b++) begin
            beat = 1; tick(); beat = 0;
            if (b < 3) begin
                total++; if (note_done !== 1'b0 || busy !== 1'b1) begin
                    bad++; $display("FAIL basic_mid_beat%0d: done=%b busy=%b want done=0 busy=1", b, note_done, busy);
                end
                tick();
            end
        end
        total++; if (note_done !== 1'b1) begin bad++; $display("FAIL basic_done: got %b want 1", note_done); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_fall: got %b want 0", busy); end
        tick();
        total++; if (note_done !== 1'b0) begin bad++; $display("FAIL basic_done_once: got %b want 0", note_done); end
        gen = 1; tick(); gen = 0;
        total++; if (phase !== 22'(ph) || step_size !== 20'(s)) begin
            bad++; $display("FAIL basic_idle_hold: phase=%0d step=%0d want phase=%0d step=%0d", phase, step_size, ph, s);
        end
    endtask

    task automatic test_zero_duration();
        int n = $urandom_range(1, 63);
        apply_reset();
        play = $urandom_range(0, 1);
        start_note(n, 0);
        total++; if (note_done !== 1'b0 || step_size !== 20'(exp_step(n))) begin
            bad++; $display("FAIL zero_load: done=%b step=%0d want done=0 step=%0d", note_done, step_size, exp_step(n));
        end
        tick();
        total++; if (note_done !== 1'b1) begin bad++; $display("FAIL zero_done: got %b want 1", note_done); end
        tick();
        total++; if (note_done !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL zero_after: done=%b busy=%b want 0 0", note_done, busy);
        end
    endtask

    task automatic test_pause();
        int n = $urandom_range(1, 63);
        int s = exp_step(n);
        int ph = 0;
        int seen = 0;
        apply_reset();
        play = 1;
        start_note(n, 6);
        tick();
        beat = 1; gen = 1; tick(); beat = 0; gen = 0;
        ph = s;
        play = 0;
        for (int i = 0; i < 20; i++) begin
            gen = 1; beat = (i % 4 == 0);
            tick();
            if (note_done) seen++;
        end
        gen = 0; beat = 0;
        total++; if (phase !== 22'(ph)) begin bad++; $display("FAIL pause_phase: got %0d want %0d", phase, ph); end
        total++; if (seen != 0 || busy !== 1'b1) begin
            bad++; $display("FAIL pause_hold: done_pulses=%0d busy=%b want 0 1", seen, busy);
        end
        play = 1;
        for (int b = 1; b <= 5; b++) begin
            beat = 1; gen = 1; tick(); beat = 0; gen = 0;
            ph = (ph + s) % 4194304;
            if (b < 5) begin
                total++; if (note_done !== 1'b0) begin bad++; $display("FAIL pause_resume_beat%0d: done=%b want 0", b, note_done); end
            end
        end
        total++; if (note_done !== 1'b1) begin bad++; $display("FAIL pause_resume_done: got %b want 1", note_done); end
        total++; if (phase !== 22'(ph)) begin bad++; $display("FAIL pause_resume_phase: got %0d want %0d", phase, ph); end
    endtask

    task automatic test_back_to_back();
        int s37 = exp_step(37);
        apply_reset();
        play = 1;
        start_note(49, 1);
        tick();
        beat = 1; tick(); beat = 0;
        total++; if (note_done !== 1'b1) begin bad++; $display("FAIL b2b_first_done: got %b want 1", note_done); end
        start_note(37, 2);
        total++; if (note_done !== 1'b0 || busy !== 1'b1 || step_size !== 20'(s37)) begin
            bad++; $display("FAIL b2b_accept: done=%b busy=%b step=%0d want 0 1 %0d", note_done, busy, step_size, s37);
        end
        tick();
        start_note(1, 0);
        total++; if (step_size !== 20'(s37) || busy !== 1'b1) begin
            bad++; $display("FAIL b2b_ignore: step=%0d busy=%b want %0d 1", step_size, busy, s37);
        end
        beat = 1; tick(); beat = 0;
        total++; if (note_done !== 1'b0) begin bad++; $display("FAIL b2b_beat1: done=%b want 0", note_done); end
        tick();
        total++; if (note_done !== 1'b0) begin bad++; $display("FAIL b2b_gap: done=%b want 0", note_done); end
        beat = 1; tick(); beat = 0;
        total++; if (note_done !== 1'b1) begin bad++; $display("FAIL b2b_second_done: got %b want 1", note_done); end
        tick();
        total++; if (note_done !== 1'b0) begin bad++; $display("FAIL b2b_done_once: got %b want 0", note_done); end
    endtask

    task automatic test_rest();
        apply_reset();
        play = 1;
        gen = 1;
        start_note(0, 2);
        total++; if (step_size !== 20'd0) begin bad++; $display("FAIL rest_step: got %0d want 0", step_size); end
        tick();
        beat = 1; tick(); tick(); beat = 0;
        total++; if (note_done !== 1'b1 || phase !== 22'd0) begin
            bad++; $display("FAIL rest_done: done=%b phase=%0d want 1 0", note_done, phase);
        end
        gen = 0;
    endtask

    task automatic test_reset_mid();
        int n = $urandom_range(1, 63);
        int n2 = $urandom_range(1, 63);
        int seen = 0;
        apply_reset();
        play = 1;
        start_note(n, 6);
        tick();
        beat = 1; gen = 1; tick(); tick(); beat = 0; gen = 0;
        #2;
        reset = 1;
        #1;
        total++; if (note_done !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL midreset_ctrl: done=%b busy=%b want 0 0", note_done, busy);
        end
        total++; if (step_size !== 20'd0 || phase !== 22'd0) begin
            bad++; $display("FAIL midreset_data: step=%0d phase=%0d want 0 0", step_size, phase);
        end
        tick();
        reset = 0;
        for (int i = 0; i < 8; i++) begin
            beat = 1; gen = 1; tick();
            if (note_done || busy) seen++;
        end
        beat = 0; gen = 0;
        total++; if (seen != 0 || phase !== 22'd0) begin
            bad++; $display("FAIL midreset_quiet: active_cycles=%0d phase=%0d want 0 0", seen, phase);
        end
        start_note(n2, 1);
        total++; if (step_size !== 20'(exp_step(n2))) begin
            bad++; $display("FAIL midreset_restart_step: got %0d want %0d", step_size, exp_step(n2));
        end
        tick();
        beat = 1; tick(); beat = 0;
        total++; if (note_done !== 1'b1) begin bad++; $display("FAIL midreset_restart_done: got %b want 1", note_done); end
    endtask

    // Reference: a note waits one load cycle, then counts played beats down to zero.
    task automatic test_random();
        int mode = 0;    // 0 idle, 1 loading, 2 sounding
        int m_note = 0, m_dur = 0, m_left = 0, m_step = 0, m_phase = 0;
        int nn, bt, gs, pl, cur_done, e_done, e_busy;
        apply_reset();
        for (int c = 0; c < 800; c++) begin
            nn = ($urandom_range(0, 3) == 0);
            bt = ($urandom_range(0, 2) == 0);
            gs = $urandom_range(0, 1);
            pl = ($urandom_range(0, 3) != 0);
            new_note = nn[0]; beat = bt[0]; gen = gs[0]; play = pl[0];
            note = 6'($urandom_range(0, 63)); duration = 6'($urandom_range(0, 4));
            cur_done = (mode == 2 && m_left == 0);
            if (mode == 2 && pl != 0 && gs != 0) m_phase = (m_phase + m_step) % 4194304;
            if ((mode == 0 || cur_done) && nn != 0) begin
                m_note = int'(note); m_dur = int'(duration);
                m_step = exp_step(m_note); mode = 1;
            end else if (cur_done) begin
                mode = 0;
            end else if (mode == 1) begin
                m_step = exp_step(m_note); m_left = m_dur; mode = 2;
            end else if (mode == 2 && pl != 0 && bt != 0) begin
                m_left--;
            end
            tick();
            e_done = (mode == 2 && m_left == 0);
            e_busy = (mode != 0 && e_done == 0);
            total++; if (note_done !== e_done[0]) begin
                bad++; $display("FAIL rand_done c=%0d: got %b want %0d", c, note_done, e_done);
            end
            total++; if (busy !== e_busy[0]) begin
                bad++; $display("FAIL rand_busy c=%0d: got %b want %0d", c, busy, e_busy);
            end
            total++; if (step_size !== 20'(m_step)) begin
                bad++; $display("FAIL rand_step c=%0d: got %0d want %0d", c, step_size, m_step);
            end
            total++; if (phase !== 22'(m_phase)) begin
                bad++; $display("FAIL rand_phase c=%0d: got %0d want %0d", c, phase, m_phase);
            end
        end
        new_note = 0; beat = 0; gen = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_duration();
        test_pause();
        test_back_to_back();
        test_rest();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/note_player.md
NOTE_PLAYER -- requirements
Module: note_player

Interface
REQ-001 SHALL expose port: clk  input  1  system clock; every register updates on its rising edge.
REQ-002 SHALL expose port: reset  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-003 SHALL expose port: play  input  1  level; 1 = run, 0 = pause (freeze all counting).
REQ-004 SHALL expose port: note  input  6  note index from song_reader; 0 = rest, 1..63 = semitones, 49 = A4.
REQ-005 SHALL expose port: duration  input  6  note length in beats; 0 = zero-length note.
REQ-006 SHALL expose port: new_note  input  1  one-cycle strobe; note/duration valid this cycle.
REQ-007 SHALL expose port: beat  input  1  one-cycle beat tick from the beat generator.
REQ-008 SHALL expose port: generate_next_sample  input  1  one-cycle sample-rate (48 kHz) tick.
REQ-009 SHALL expose port: note_done  output  1  one-cycle pulse: current note finished; returned to song_reader.
REQ-010 SHALL expose port: step_size  output  20  phase increment of the current note.
REQ-011 SHALL expose port: phase  output  22  phase accumulator, feeds the sine lookup.
REQ-012 SHALL expose port: busy  output  1  high while in LOAD or PLAYING.

Function
REQ-013 SHALL implement FSM states IDLE, LOAD, PLAYING.
REQ-014 IDLE: on new_note=1 SHALL latch note and duration, then go to LOAD; play is not required for acceptance.
REQ-015 LOAD: SHALL last exactly 1 cycle; SHALL register the ROM step for the latched note into step_size; SHALL load beats_left = latched duration; SHALL go to PLAYING.
REQ-016 PLAYING, beats_left=0: SHALL pulse note_done for 1 cycle and go to IDLE, regardless of play.
REQ-017 PLAYING, play=1, beat=1, beats_left=1: SHALL pulse note_done in the next cycle and go to IDLE.
REQ-018 PLAYING, play=1, beat=1, beats_left>1: SHALL decrement beats_left; beat with play=0 SHALL be ignored.
REQ-019 SHALL ignore new_note while in LOAD or PLAYING; the latched note SHALL be unaffected.
REQ-020 SHALL accept new_note in IDLE even when it coincides with the note_done cycle, giving back-to-back notes with no gap cycle.
REQ-021 Latency: new_note to valid step_size = 1 cycle; final counted beat to note_done = 1 cycle.
REQ-022 phase SHALL advance by step_size, mod 2^22, on generate_next_sample=1 only when play=1 and the state is PLAYING; phase SHALL wrap silently.
REQ-023 step_size SHALL hold its value in IDLE (last note sustains its value but phase stops); rest note 0 SHALL give step_size=0.
REQ-024 ROM contents SHALL be step(n) = round(440*2^((n-49)/12) * 2^22 / 48000) for n=1..63, and step(0)=0; note 49 gives 38448.
REQ-025 note_done SHALL never be high for two consecutive cycles.

Reset
REQ-026 Asserting reset at any time, including mid-note, SHALL force IDLE, note_done=0, busy=0, step_size=0, phase=0, beats_left=0, and latched note/duration=0.
REQ-027 After reset deasserts, the first accepted new_note SHALL behave exactly as from power-up.

Structure
REQ-028 The shared package SHALL hold the FSM state encoding, NOTE_W=6, DUR_W=6, STEP_W=20, PHASE_W=22, and REST_NOTE=0.
REQ-029 SHALL contain one sub-module, frequency_rom: 64x20 combinational lookup (note -> step), registered by note_player in LOAD.

Verification
REQ-030 Scenario: reset; new_note with note=49, duration=3; play=1; 3 beats -> step_size=38448 from the cycle after new_note; note_done exactly 1 cycle after the 3rd beat; busy falls the same cycle.
REQ-031 Scenario: duration=0 strobe -> note_done 2 cycles after new_note (LOAD, then PLAYING); no beat needed.
REQ-032 Scenario: play=0 during PLAYING with 5 beats and 20 sample ticks -> beats_left unchanged and phase unchanged; resume play=1 -> countdown continues from the held value.
REQ-033 Scenario: new_note in the note_done cycle, note 37, duration 2 -> accepted; step_size=19224; second new_note during PLAYING is ignored.
REQ-034 Scenario: note=0, duration=2 -> step_size=0, phase constant, note_done after 2 beats.
REQ-035 Scenario: reset pulse mid-note (beats_left=4) -> all outputs 0 within the reset cycle; no note_done pulse after release.
